// File: rtl/morse_encoder_pkg.sv
// Shared definitions for the Morse transmit path: code space, gap lengths,
// FSM state encoding and the character-to-symbol lookup.
package morse_pkg;

    localparam logic [5:0] CODE_SPACE     = 6'd36;
    localparam logic [5:0] CODE_MAX_VALID = 6'd36;

    // Interval lengths in Morse units
    localparam logic [2:0] ELEM_GAP_U = 3'd1;
    localparam logic [2:0] CHAR_GAP_U = 3'd3;
    localparam logic [2:0] WORD_GAP_U = 3'd4;
    localparam logic [2:0] DASH_U     = 3'd3;
    localparam logic [2:0] DOT_U      = 3'd1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_MARK     = 3'd1,
        ST_ELEM_GAP = 3'd2,
        ST_CHAR_GAP = 3'd3,
        ST_WORD_GAP = 3'd4
    } morse_state_e;

    // len = number of elements, pat = element i in bit i, 1 = dash
    typedef struct packed {
        logic [2:0] len;
        logic [4:0] pat;
    } morse_sym_t;

    function automatic morse_sym_t morse_lookup(input logic [5:0] code);
        morse_sym_t sym;
        case (code)
            6'd0:  sym = {3'd2, 5'b00010}; // A .-
            6'd1:  sym = {3'd4, 5'b00001}; // B -...
            6'd2:  sym = {3'd4, 5'b00101}; // C -.-.
            6'd3:  sym = {3'd3, 5'b00001}; // D -..
            6'd4:  sym = {3'd1, 5'b00000}; // E .
            6'd5:  sym = {3'd4, 5'b00100}; // F ..-.
            6'd6:  sym = {3'd3, 5'b00011}; // G --.
            6'd7:  sym = {3'd4, 5'b00000}; // H ....
            6'd8:  sym = {3'd2, 5'b00000}; // I ..
            6'd9:  sym = {3'd4, 5'b01110}; // J .---
            6'd10: sym = {3'd3, 5'b00101}; // K -.-
            6'd11: sym = {3'd4, 5'b00010}; // L .-..
            6'd12: sym = {3'd2, 5'b00011}; // M --
            6'd13: sym = {3'd2, 5'b00001}; // N -.
            6'd14: sym = {3'd3, 5'b00111}; // O ---
            6'd15: sym = {3'd4, 5'b00110}; // P .--.
            6'd16: sym = {3'd4, 5'b01011}; // Q --.-
            6'd17: sym = {3'd3, 5'b00010}; // R .-.
            6'd18: sym = {3'd3, 5'b00000}; // S ...
            6'd19: sym = {3'd1, 5'b00001}; // T -
            6'd20: sym = {3'd3, 5'b00100}; // U ..-
            6'd21: sym = {3'd4, 5'b01000}; // V ...-
            6'd22: sym = {3'd3, 5'b00110}; // W .--
            6'd23: sym = {3'd4, 5'b01001}; // X -..-
            6'd24: sym = {3'd4, 5'b01101}; // Y -.--
            6'd25: sym = {3'd4, 5'b00011}; // Z --..
            6'd26: sym = {3'd5, 5'b11111}; // 0 -----
            6'd27: sym = {3'd5, 5'b11110}; // 1 .----
            6'd28: sym = {3'd5, 5'b11100}; // 2 ..---
            6'd29: sym = {3'd5, 5'b11000}; // 3 ...--
            6'd30: sym = {3'd5, 5'b10000}; // 4 ....-
            6'd31: sym = {3'd5, 5'b00000}; // 5 .....
            6'd32: sym = {3'd5, 5'b00001}; // 6 -....
            6'd33: sym = {3'd5, 5'b00011}; // 7 --...
            6'd34: sym = {3'd5, 5'b00111}; // 8 ---..
            6'd35: sym = {3'd5, 5'b01111}; // 9 ----.
            default: sym = '0;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/morse_encoder_unit_tick.sv
// Reloadable down-counter: unit_tick_o is high for one cycle every
// load_val_i+1 cycles. reload_i restarts the count from load_val_i so a new
// character always begins on a full unit.
module morse_unit_tick #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reload_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             unit_tick_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload on request or on wrap, otherwise count down
    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (reload_i || (cnt_q == '0)) begin
            cnt_d = load_val_i;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign unit_tick_o = (cnt_q == '0);

endmodule

// File: rtl/morse_encoder.sv
// Morse transmitter: accepts character codes over valid/ready and keys
// serial_out with dots, dashes and gaps timed in units of BASE_DIV << spec.
// Optional macro MORSE_ENC_SKID_EN adds a one-entry holding register so the
// next character can be accepted while the current one is transmitted.
//
// Handshake: a character transfers on a rising clk edge where char_valid and
// char_ready are both high; char_in and spec are captured on that edge.
module morse_encoder
    import morse_pkg::*;
#(
    parameter int BASE_DIV = 12,
    parameter int CHAR_W   = 6,
    parameter int SPEC_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SPEC_W-1:0] spec,
    input  logic [CHAR_W-1:0] char_in,
    input  logic              char_valid,
    output logic              char_ready,
    output logic              serial_out,
    output logic              char_done,
    output logic              char_err,
    output morse_state_e      state_dbg
);

    localparam int CNT_W = $clog2(BASE_DIV << 7);

    morse_state_e      state_q, state_d;
    logic [SPEC_W-1:0] spec_q, spec_d;
    logic [2:0]        len_q, len_d;
    logic [4:0]        pat_q, pat_d;
    logic [2:0]        elem_q, elem_d;
    logic [2:0]        unit_q, unit_d;
    logic              err_q, err_d;
    logic              up_q;

    logic              unit_tick;
    logic [2:0]        intv_len;
    logic              last_unit;
    logic              done_w;
    logic              ready_w;
    logic              accept;
    logic              start_vld;
    logic [CHAR_W-1:0] start_code;
    logic [SPEC_W-1:0] start_spec;
    logic [SPEC_W-1:0] load_spec;
    logic [CNT_W-1:0]  unit_load;
    morse_sym_t        sym;

    assign accept = char_valid && ready_w;

`ifdef MORSE_ENC_SKID_EN
    logic              hold_vld_q, hold_vld_d;
    logic [CHAR_W-1:0] hold_code_q, hold_code_d;
    logic [SPEC_W-1:0] hold_spec_q, hold_spec_d;

    assign ready_w = up_q && !hold_vld_q;

    // Choose what starts next: held entry at char_done, otherwise direct input
    always_comb begin
        start_vld   = 1'b0;
        start_code  = char_in;
        start_spec  = spec;
        hold_vld_d  = hold_vld_q;
        hold_code_d = hold_code_q;
        hold_spec_d = hold_spec_q;
        if (done_w && hold_vld_q) begin
            start_vld  = 1'b1;
            start_code = hold_code_q;
            start_spec = hold_spec_q;
            hold_vld_d = 1'b0;
        end else if (accept && ((state_q == ST_IDLE) || done_w)) begin
            start_vld = 1'b1;
        end else if (accept) begin
            hold_vld_d  = 1'b1;
            hold_code_d = char_in;
            hold_spec_d = spec;
        end
    end

    // Holding register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_vld_q  <= 1'b0;
            hold_code_q <= '0;
            hold_spec_q <= '0;
        end else begin
            hold_vld_q  <= hold_vld_d;
            hold_code_q <= hold_code_d;
            hold_spec_q <= hold_spec_d;
        end
    end
`else
    assign ready_w    = up_q && (state_q == ST_IDLE);
    assign start_vld  = accept;
    assign start_code = char_in;
    assign start_spec = spec;
`endif

    // Unit length follows the incoming spec at start, the latched one after
    assign load_spec = start_vld ? start_spec : spec_q;
    assign unit_load = CNT_W'((BASE_DIV << load_spec) - 1);

    morse_unit_tick #(
        .CNT_W (CNT_W)
    ) u_unit_tick (
        .clk         (clk),
        .rst         (rst),
        .reload_i    (start_vld),
        .load_val_i  (unit_load),
        .unit_tick_o (unit_tick)
    );

    // Length in units of the interval the FSM is currently in
    always_comb begin
        intv_len = ELEM_GAP_U;
        case (state_q)
            ST_MARK:     intv_len = pat_q[elem_q] ? DASH_U : DOT_U;
            ST_ELEM_GAP: intv_len = ELEM_GAP_U;
            ST_CHAR_GAP: intv_len = CHAR_GAP_U;
            ST_WORD_GAP: intv_len = WORD_GAP_U;
            default:     intv_len = ELEM_GAP_U;
        endcase
    end

    assign last_unit = unit_tick && (unit_q == (intv_len - 3'd1)) && (state_q != ST_IDLE);
    assign done_w    = last_unit && ((state_q == ST_CHAR_GAP) || (state_q == ST_WORD_GAP));
    assign sym       = morse_lookup(start_code);

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        spec_d  = spec_q;
        len_d   = len_q;
        pat_d   = pat_q;
        elem_d  = elem_q;
        unit_d  = unit_q;
        err_d   = 1'b0;
        if (last_unit) begin
            unit_d = 3'd0;
            case (state_q)
                ST_MARK: begin
                    if (elem_q == (len_q - 3'd1)) begin
                        state_d = ST_CHAR_GAP;
                    end else begin
                        state_d = ST_ELEM_GAP;
                    end
                end
                ST_ELEM_GAP: begin
                    elem_d  = elem_q + 3'd1;
                    state_d = ST_MARK;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (unit_tick && (state_q != ST_IDLE)) begin
            unit_d = unit_q + 3'd1;
        end
        if (start_vld) begin
            spec_d = start_spec;
            unit_d = 3'd0;
            elem_d = 3'd0;
            if (start_code < CODE_SPACE) begin
                len_d   = sym.len;
                pat_d   = sym.pat;
                state_d = ST_MARK;
            end else if (start_code == CODE_MAX_VALID) begin
                state_d = ST_WORD_GAP;
            end else begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Character context, error pulse and post-reset ready enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spec_q <= '0;
            len_q  <= '0;
            pat_q  <= '0;
            elem_q <= '0;
            unit_q <= '0;
            err_q  <= 1'b0;
            up_q   <= 1'b0;
        end else begin
            spec_q <= spec_d;
            len_q  <= len_d;
            pat_q  <= pat_d;
            elem_q <= elem_d;
            unit_q <= unit_d;
            err_q  <= err_d;
            up_q   <= 1'b1;
        end
    end

    // Outputs decoded from state
    always_comb begin
        serial_out = (state_q == ST_MARK);
        char_done  = done_w;
        char_err   = err_q;
        char_ready = ready_w;
        state_dbg  = state_q;
    end

endmodule

// File: tb/tb_morse_encoder.sv
// Self-checking bench for morse_encoder. Expected line activity is built
// from dot/dash strings per character and compared cycle by cycle.
module tb_morse_encoder;
    import morse_pkg::*;

    localparam int BASE_DIV = 12;
`ifdef MORSE_ENC_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   spec = 3'd0;
    logic [5:0]   char_in = 6'd0;
    logic         char_valid = 1'b0;
    logic         char_ready;
    logic         serial_out;
    logic         char_done;
    logic         char_err;
    morse_state_e state_dbg;

    int checks = 0;
    int errors = 0;

    logic exp_q[$];
    int   done_q[$];
    logic ready_log[$];

    string morse_tbl [36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
        ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
        "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....",
        "--...", "---..", "----."
    };

    morse_encoder #(
        .BASE_DIV (BASE_DIV),
        .CHAR_W   (6),
        .SPEC_W   (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spec       (spec),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .serial_out (serial_out),
        .char_done  (char_done),
        .char_err   (char_err),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: append the expected line pattern for one character
    task automatic model_char(input int code, input int u);
        string s;
        int    m;
        if (code < 36) begin
            s = morse_tbl[code];
            for (int i = 0; i < s.len(); i++) begin
                m = (s.getc(i) == 8'd45) ? 3 * u : u;
                repeat (m) exp_q.push_back(1'b1);
                if (i != s.len() - 1) repeat (u) exp_q.push_back(1'b0);
            end
            repeat (3 * u) exp_q.push_back(1'b0);
            done_q.push_back(exp_q.size() - 1);
        end else if (code == 36) begin
            repeat (4 * u) exp_q.push_back(1'b0);
            done_q.push_back(exp_q.size() - 1);
        end
    endtask

    task automatic send(input int code, input int sp);
        @(negedge clk);
        checks++;
        if (char_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_send code=%0d got %b want 1", code, char_ready);
        end
        char_in    = 6'(code);
        spec       = 3'(sp);
        char_valid = 1'b1;
        @(posedge clk);
        #1 char_valid = 1'b0;
    endtask

    // Sample n cycles after a transfer and compare against the model queues
    task automatic check_wave(input string name, input int n, input int err_at,
                              input bit drop_at0, input int spec_at, input int new_spec);
        int   wave_mis, done_mis, err_mis, rdy_mis, first_w;
        logic exp_bit, exp_done, exp_err, exp_rdy;
        wave_mis = 0; done_mis = 0; err_mis = 0; rdy_mis = 0; first_w = -1;
        ready_log.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_bit  = (i < exp_q.size()) ? exp_q[i] : 1'b0;
            exp_done = 1'b0;
            foreach (done_q[k]) if (done_q[k] == i) exp_done = 1'b1;
            exp_err  = (i == err_at);
            exp_rdy  = SKID ? 1'b1 : (i >= exp_q.size());
            if (serial_out !== exp_bit) begin
                wave_mis++;
                if (first_w < 0) first_w = i;
            end
            if (char_done !== exp_done) done_mis++;
            if (char_err !== exp_err) err_mis++;
            if (!drop_at0 && (char_ready !== exp_rdy)) rdy_mis++;
            ready_log.push_back(char_ready);
            if (i == spec_at) spec = 3'(new_spec);
            if (drop_at0 && i == 0) begin
                @(posedge clk);
                #1 char_valid = 1'b0;
            end
        end
        checks++;
        if (wave_mis !== 0) begin
            errors++;
            $display("FAIL %s serial_out: %0d cycles differ, first at cycle %0d, want 0 differing", name, wave_mis, first_w);
        end
        checks++;
        if (done_mis !== 0) begin
            errors++;
            $display("FAIL %s char_done: %0d cycles differ, want 0", name, done_mis);
        end
        checks++;
        if (err_mis !== 0) begin
            errors++;
            $display("FAIL %s char_err: %0d cycles differ, want 0", name, err_mis);
        end
        if (!drop_at0) begin
            checks++;
            if (rdy_mis !== 0) begin
                errors++;
                $display("FAIL %s char_ready: %0d cycles differ, want 0", name, rdy_mis);
            end
        end
        exp_q.delete();
        done_q.delete();
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({serial_out, char_ready, char_done, char_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0000", {serial_out, char_ready, char_done, char_err});
        end
        checks++;
        if (state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_state got %0d want %0d", state_dbg, ST_IDLE);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (char_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold_ready got %b want 0", char_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (char_ready !== 1'b0) begin
            errors++;
            $display("FAIL release_ready_early got %b want 0", char_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (char_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready got %b want 1", char_ready);
        end
    endtask

    task automatic test_letters();
        send(4, 0);
        model_char(4, BASE_DIV);
        check_wave("E", exp_q.size() + 1, -1, 1'b0, -1, 0);
        send(0, 0);
        model_char(0, BASE_DIV);
        check_wave("A", exp_q.size() + 1, -1, 1'b0, -1, 0);
    endtask

    task automatic test_spec_latch();
        send(19, 2);
        model_char(19, BASE_DIV << 2);
        check_wave("T_spec2", exp_q.size() + 1, -1, 1'b0, 20, 0);
    endtask

    task automatic test_space_invalid();
        send(36, 0);
        model_char(36, BASE_DIV);
        check_wave("space", exp_q.size() + 1, -1, 1'b0, -1, 0);
        send(63, 0);
        model_char(63, BASE_DIV);
        check_wave("invalid63", 6, 0, 1'b0, -1, 0);
    endtask

    task automatic test_random();
        int code, sp;
        for (int n = 0; n < 8; n++) begin
            code = $urandom_range(0, 63);
            sp   = $urandom_range(0, 1);
            send(code, sp);
            model_char(code, BASE_DIV << sp);
            if (code > 36)
                check_wave($sformatf("rand_code%0d", code), 4, 0, 1'b0, -1, 0);
            else
                check_wave($sformatf("rand_code%0d", code), exp_q.size() + 1, -1, 1'b0, -1, 0);
        end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        send(26, 0);
        for (int i = 0; i < 50; i++) @(negedge clk);
        checks++;
        if (serial_out !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_mark got %b want 1", serial_out);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (serial_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_serial got %b want 0", serial_out);
        end
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (char_done !== 1'b0) done_seen++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (char_ready !== 1'b1 || state_dbg !== ST_IDLE) begin
            errors++;
            $display("FAIL reset_mid_release ready=%b state=%0d want ready=1 state=%0d", char_ready, state_dbg, ST_IDLE);
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (char_done !== 1'b0 || serial_out !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL reset_mid_discard got %0d active cycles want 0", done_seen);
        end
    endtask

`ifdef MORSE_ENC_SKID_EN
    task automatic test_back_to_back();
        @(negedge clk);
        char_in    = 6'd4;
        spec       = 3'd0;
        char_valid = 1'b1;
        @(posedge clk);
        #1 char_in = 6'd19;
        model_char(4, BASE_DIV);
        model_char(19, BASE_DIV);
        check_wave("skid_E_T", exp_q.size() + 1, -1, 1'b1, -1, 0);
        checks++;
        if (ready_log[0] !== 1'b1 || ready_log[1] !== 1'b0 || ready_log[48] !== 1'b1) begin
            errors++;
            $display("FAIL skid_ready got %b%b%b want 101", ready_log[0], ready_log[1], ready_log[48]);
        end
    endtask
`else
    task automatic test_back_to_back();
        send(19, 0);
        model_char(19, BASE_DIV);
        check_wave("b2b_T", exp_q.size() + 1, -1, 1'b0, -1, 0);
        send(36, 1);
        model_char(36, BASE_DIV << 1);
        check_wave("b2b_space", exp_q.size() + 1, -1, 1'b0, -1, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_letters();
        test_spec_latch();
        test_space_invalid();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/morse_encoder.md
Name: morse_encoder

Overview:
- Transmit-side counterpart of the Morse decipher path. Accepts 6-bit character codes over a valid/ready handshake and drives a serial on/off keyed Morse line.
- Uses the same code space, spec speed selector and unit timing as the receiver, so this block's serial_out can loop back into the receiver's noisy_in.
- Sits between the character source (host or test logic) and the physical or loopback serial line.

Parameters:
- BASE_DIV, 12, clk cycles per Morse unit at spec=3'b000.
- CHAR_W, 6, character code width.
- SPEC_W, 3, speed selector width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- spec  in  SPEC_W  speed select; unit = BASE_DIV << spec cycles
- char_in  in  CHAR_W  character code
- char_valid  in  1  char_in is valid
- char_ready  out  1  block can accept a character
- serial_out  out  1  keyed Morse line, 1 = mark
- char_done  out  1  one-cycle pulse when a character's trailing gap ends
- char_err  out  1  one-cycle pulse when an invalid code is accepted

Behaviour:
- Reset (rst=0, asynchronous): serial_out=0, char_ready=0, char_done=0, char_err=0, FSM=IDLE, counters cleared. char_ready rises on the first clk edge after rst deasserts.
- Code map:
  - 0-25 = A-Z
  - 26-35 = digits 0-9
  - 36 = word space
  - 37-63 = invalid
- Symbol table: each entry holds a length (1-5 elements) and a 5-bit pattern, LSB first, 1=dash. Example: A len 2, pattern 2'b10 (dot then dash).
- Handshake: transfer occurs on a clk edge with char_valid & char_ready. spec and char_in are latched at transfer; later spec changes do not affect the character in flight.
- Unit timing:
  - Unit tick counter reloads at transfer.
  - Every interval lasts an exact multiple of U = BASE_DIV << spec cycles.
  - Counter width is $clog2(BASE_DIV<<7).
- FSM states: IDLE, MARK, ELEM_GAP, CHAR_GAP, WORD_GAP.
  - IDLE: char_ready=1, serial_out=0.
  - Valid letter/digit: the cycle after transfer enters MARK with serial_out=1 (latency 1 cycle).
  - MARK: lasts 1U for a dot, 3U for a dash. Then goes to ELEM_GAP (1U low) if elements remain, else CHAR_GAP (3U low).
  - ELEM_GAP: returns to MARK for the next element.
  - Space code 36: the cycle after transfer enters WORD_GAP, 4U low. A preceding character's 3U gap plus these 4U gives the standard 7U word gap.
  - End of CHAR_GAP or WORD_GAP: char_done=1 for one cycle; the FSM returns to IDLE in the same cycle, so char_ready=1 on the next cycle.
  - Invalid code: accepted, no line activity, char_err=1 for exactly the next cycle, FSM stays IDLE, char_ready stays 1.
- char_ready=0 in every state except IDLE (base build).
- char_done and char_err are never asserted together.
- Reset mid-character: serial_out drops to 0 immediately; the partial character is discarded with no char_done.

Optional Feature:
- MORSE_ENC_SKID_EN defined:
  - A one-entry holding register keeps char_ready=1 while transmitting, until the holding register is full.
  - On char_done, a held character starts transfer-equivalent processing in the same cycle. The next MARK or WORD_GAP begins 1 cycle after char_done, with no extra idle gap.
  - Held spec is latched with the held character.
  - Invalid held codes pulse char_err when dequeued.
- MORSE_ENC_SKID_EN undefined: behaviour exactly as above; no holding register.

Decomposition:
- Package morse_pkg contains:
  - code constants (CODE_SPACE=36, CODE_MAX_VALID=36)
  - the symbol length/pattern lookup function
  - FSM state enum
  - gap constants: ELEM_GAP_U=1, CHAR_GAP_U=3, WORD_GAP_U=4, DASH_U=3
- One sub-module, morse_unit_tick: a reloadable down-counter producing a one-cycle unit_tick every U cycles, with a reload input driven at transfer.

Test Plan:
- BASE_DIV=12, spec=0, send 'E' (4) -> serial_out high 12 cycles starting 1 cycle after transfer, low 36, char_done pulse, char_ready high next cycle.
- spec=0, send 'A' (0) -> high 12, low 12, high 36, low 36, char_done.
- spec=2, send 'T' (19) -> high 144 cycles, low 144, char_done; change spec to 0 mid-mark -> timing unchanged.
- Send 36 then 63 -> 48 low cycles then char_done; code 63 -> char_err pulse next cycle, serial_out stays 0, no char_done.
- spec=0, send '0' (26, five dashes), assert rst low at cycle 50 -> serial_out=0 immediately, no char_done, char_ready=1 one cycle after release.
- MORSE_ENC_SKID_EN: hold char_valid with 'E' then 'T' back-to-back -> second accepted during first; 'T' mark starts 1 cycle after first char_done.
